// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-state engine.
// Holds the visible-area constants, the serve-centre coordinates, the game FSM
// state type and the signed coordinate type used for ball step/compare math.
package pong_pkg;

  localparam int H_VIS = 640;
  localparam int V_VIS = 480;

  // Top-left of an 8x8 ball centred in the visible area, and the paddle rest row.
  localparam logic [9:0] BALL_CX        = 10'd316;
  localparam logic [9:0] BALL_CY        = 10'd236;
  localparam logic [9:0] PADDLE_START_Y = 10'd208;

  typedef enum logic [1:0] {
    SERVE,
    PLAY,
    POINT,
    GAME_OVER
  } state_e;

  // 11-bit signed so a step past either screen edge stays comparable.
  typedef logic signed [10:0] coord_t;

endpackage

// File: rtl/paddle_ctrl.sv
// One paddle: 2-flop synchronisers for its raw up/down buttons and the
// per-frame move/clamp of its y position.
// Ports:
//   clk50M, reset          clock, synchronous active-high reset
//   frame_tick             one-cycle frame update strobe
//   freeze                 hold position (game over)
//   up_raw, down_raw       asynchronous button inputs
//   up_sync, down_sync     synchronised button levels
//   y                      paddle top y (registered)
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_SPEED = 4
) (
  input  logic       clk50M,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       freeze,
  input  logic       up_raw,
  input  logic       down_raw,
  output logic       up_sync,
  output logic       down_sync,
  output logic [9:0] y
);

  localparam logic [9:0] Y_MAX = 10'(V_VIS - PADDLE_H);
  localparam logic [9:0] SPEED = 10'(PADDLE_SPEED);

  logic       up_meta_q, up_sync_q;
  logic       down_meta_q, down_sync_q;
  logic [9:0] y_q, y_d;

  always_comb begin
    y_d = y_q;
    if (frame_tick && !freeze) begin
      if (up_sync_q && !down_sync_q) begin
        y_d = (y_q < SPEED) ? '0 : y_q - SPEED;
      end else if (down_sync_q && !up_sync_q) begin
        // Compare against Y_MAX - SPEED so the sum never needs an extra bit.
        y_d = (y_q > Y_MAX - SPEED) ? Y_MAX : y_q + SPEED;
      end
    end
  end

  always_ff @(posedge clk50M) begin
    if (reset) begin
      up_meta_q   <= 1'b0;
      up_sync_q   <= 1'b0;
      down_meta_q <= 1'b0;
      down_sync_q <= 1'b0;
      y_q         <= PADDLE_START_Y;
    end else begin
      up_meta_q   <= up_raw;
      up_sync_q   <= up_meta_q;
      down_meta_q <= down_raw;
      down_sync_q <= down_meta_q;
      y_q         <= y_d;
    end
  end

  assign up_sync   = up_sync_q;
  assign down_sync = down_sync_q;
  assign y         = y_q;

endmodule

// File: rtl/pong_engine.sv
// Pong game-state engine: ball, paddles, scores and serve/point sequencing,
// updated once per frame on the rising (trailing) edge of the active-low VS.
// Optional macro PONG_BALL_SPEEDUP_EN: ball speed register that grows by one
// per paddle hit (saturating at 2*BALL_SPEED) and resets on each serve.
// Ports:
//   clk50M, reset                    clock, synchronous active-high reset
//   VS                               vertical sync, active low, asynchronous
//   p1_up, p1_down, p2_up, p2_down   raw buttons, asynchronous
//   ball_x, ball_y                   ball top-left
//   paddle_one_x/y, paddle_two_x/y   paddle top-left (x constant)
//   score_one, score_two             scores
//   game_over                        high when either score reaches WIN_SCORE
module pong_engine
  import pong_pkg::*;
#(
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_ONE_X = 16,
  parameter int PADDLE_TWO_X = 616,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk50M,
  input  logic       reset,
  input  logic       VS,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_one_x,
  output logic [9:0] paddle_one_y,
  output logic [9:0] paddle_two_x,
  output logic [9:0] paddle_two_y,
  output logic [3:0] score_one,
  output logic [3:0] score_two,
  output logic       game_over
);

  localparam coord_t L_EDGE = coord_t'(PADDLE_ONE_X + PADDLE_W);
  localparam coord_t R_EDGE = coord_t'(PADDLE_TWO_X - BALL_SIZE);
  localparam coord_t X_MAX  = coord_t'(H_VIS - BALL_SIZE);
  localparam coord_t Y_MAX  = coord_t'(V_VIS - BALL_SIZE);
  localparam coord_t BS     = coord_t'(BALL_SIZE);
  localparam coord_t PH     = coord_t'(PADDLE_H);

  logic       vs_meta_q, vs_sync_q, vs_prev_q;
  logic       frame_tick;
  logic       p1_up_s, p1_down_s, p2_up_s, p2_down_s;
  logic       freeze;

  state_e     state_q, state_d;
  logic [7:0] serve_cnt_q, serve_cnt_d;
  logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;  // 1 = right / down
  logic [3:0] score_one_q, score_one_d, score_two_q, score_two_d;
  logic       game_over_q, game_over_d;

  coord_t     step, bx, by, nx, ny, p1y, p2y;
  logic       hit_one, hit_two;

`ifdef PONG_BALL_SPEEDUP_EN
  logic [2:0] speed_q, speed_d;
  assign step = coord_t'({8'd0, speed_q});
`else
  assign step = coord_t'(BALL_SPEED);
`endif

  // Idle level of VS is high, so the synchroniser resets high to avoid a
  // spurious frame tick straight out of reset.
  assign frame_tick = vs_sync_q & ~vs_prev_q;
  assign freeze     = (state_q == GAME_OVER);

  paddle_ctrl #(.PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)) u_paddle_one (
    .clk50M    (clk50M),
    .reset     (reset),
    .frame_tick(frame_tick),
    .freeze    (freeze),
    .up_raw    (p1_up),
    .down_raw  (p1_down),
    .up_sync   (p1_up_s),
    .down_sync (p1_down_s),
    .y         (paddle_one_y)
  );

  paddle_ctrl #(.PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)) u_paddle_two (
    .clk50M    (clk50M),
    .reset     (reset),
    .frame_tick(frame_tick),
    .freeze    (freeze),
    .up_raw    (p2_up),
    .down_raw  (p2_down),
    .up_sync   (p2_up_s),
    .down_sync (p2_down_s),
    .y         (paddle_two_y)
  );

  assign bx  = coord_t'({1'b0, ball_x_q});
  assign by  = coord_t'({1'b0, ball_y_q});
  assign p1y = coord_t'({1'b0, paddle_one_y});
  assign p2y = coord_t'({1'b0, paddle_two_y});
  assign nx  = dir_x_q ? bx + step : bx - step;
  assign ny  = dir_y_q ? by + step : by - step;

  // A hit needs the step to cross the paddle face from the open side, with
  // the ball's current rows overlapping the paddle.
  assign hit_one = !dir_x_q && (nx <= L_EDGE) && (bx >= L_EDGE) &&
                   (by + BS > p1y) && (by < p1y + PH);
  assign hit_two = dir_x_q && (nx >= R_EDGE) && (bx <= R_EDGE) &&
                   (by + BS > p2y) && (by < p2y + PH);

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    score_one_d = score_one_q;
    score_two_d = score_two_q;
`ifdef PONG_BALL_SPEEDUP_EN
    speed_d     = speed_q;
`endif

    if (frame_tick) begin
      unique case (state_q)
        SERVE: begin
          ball_x_d = BALL_CX;
          ball_y_d = BALL_CY;
`ifdef PONG_BALL_SPEEDUP_EN
          speed_d  = 3'(BALL_SPEED);
`endif
          if (serve_cnt_q == 8'(SERVE_FRAMES - 1)) begin
            serve_cnt_d = '0;
            state_d     = PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q + 8'd1;
          end
        end

        PLAY: begin
          if (ny <= coord_t'(0)) begin
            ball_y_d = '0;
            dir_y_d  = 1'b1;
          end else if (ny >= Y_MAX) begin
            ball_y_d = Y_MAX[9:0];
            dir_y_d  = 1'b0;
          end else begin
            ball_y_d = ny[9:0];
          end

          if (hit_one) begin
            ball_x_d = L_EDGE[9:0];
            dir_x_d  = 1'b1;
`ifdef PONG_BALL_SPEEDUP_EN
            if (speed_q < 3'(2 * BALL_SPEED)) speed_d = speed_q + 3'd1;
`endif
          end else if (hit_two) begin
            ball_x_d = R_EDGE[9:0];
            dir_x_d  = 1'b0;
`ifdef PONG_BALL_SPEEDUP_EN
            if (speed_q < 3'(2 * BALL_SPEED)) speed_d = speed_q + 3'd1;
`endif
          end else if (nx <= coord_t'(0)) begin
            ball_x_d    = '0;
            dir_x_d     = 1'b0;
            score_two_d = score_two_q + 4'd1;
            state_d     = POINT;
          end else if (nx >= X_MAX) begin
            ball_x_d    = X_MAX[9:0];
            dir_x_d     = 1'b1;
            score_one_d = score_one_q + 4'd1;
            state_d     = POINT;
          end else begin
            ball_x_d = nx[9:0];
          end
        end

        POINT: begin
          ball_x_d    = BALL_CX;
          ball_y_d    = BALL_CY;
          serve_cnt_d = '0;
          if (score_one_q == 4'(WIN_SCORE) || score_two_q == 4'(WIN_SCORE)) begin
            state_d = GAME_OVER;
          end else begin
            state_d = SERVE;
          end
        end

        GAME_OVER: begin
          ball_x_d = BALL_CX;
          ball_y_d = BALL_CY;
          if (p1_up_s || p1_down_s || p2_up_s || p2_down_s) begin
            score_one_d = '0;
            score_two_d = '0;
            serve_cnt_d = '0;
            state_d     = SERVE;
          end
        end

        default: state_d = SERVE;
      endcase
    end

    game_over_d = (score_one_d == 4'(WIN_SCORE)) || (score_two_d == 4'(WIN_SCORE));
  end

  always_ff @(posedge clk50M) begin
    if (reset) begin
      vs_meta_q   <= 1'b1;
      vs_sync_q   <= 1'b1;
      vs_prev_q   <= 1'b1;
      state_q     <= SERVE;
      serve_cnt_q <= '0;
      ball_x_q    <= BALL_CX;
      ball_y_q    <= BALL_CY;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      score_one_q <= '0;
      score_two_q <= '0;
      game_over_q <= 1'b0;
`ifdef PONG_BALL_SPEEDUP_EN
      speed_q     <= 3'(BALL_SPEED);
`endif
    end else begin
      vs_meta_q   <= VS;
      vs_sync_q   <= vs_meta_q;
      vs_prev_q   <= vs_sync_q;
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      score_one_q <= score_one_d;
      score_two_q <= score_two_d;
      game_over_q <= game_over_d;
`ifdef PONG_BALL_SPEEDUP_EN
      speed_q     <= speed_d;
`endif
    end
  end

  assign ball_x       = ball_x_q;
  assign ball_y       = ball_y_q;
  assign paddle_one_x = 10'(PADDLE_ONE_X);
  assign paddle_two_x = 10'(PADDLE_TWO_X);
  assign score_one    = score_one_q;
  assign score_two    = score_two_q;
  assign game_over    = game_over_q;

endmodule
